// File: rtl/icetap_scan_pkg.sv
// Shared chain encodings, FSM state type and chain helpers for the icetap scan master.
package icetap_scan_pkg;

  localparam int unsigned CHAIN_W = 3;

  localparam logic [CHAIN_W-1:0] CHAIN_CMD          = 3'd0;
  localparam logic [CHAIN_W-1:0] CHAIN_STATUS       = 3'd1;
  localparam logic [CHAIN_W-1:0] CHAIN_STORE_MASK   = 3'd2;
  localparam logic [CHAIN_W-1:0] CHAIN_TRIGGER_MASK = 3'd3;
  localparam logic [CHAIN_W-1:0] CHAIN_DATA         = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE_UPD,
    ST_SHIFT,
    ST_POST_UPD,
    ST_DONE
  } scan_state_t;

  function automatic logic chain_legal(input logic [CHAIN_W-1:0] c);
    return c <= CHAIN_DATA;
  endfunction

  // Status and data chains are captured and need an update before shifting.
  function automatic logic chain_reads(input logic [CHAIN_W-1:0] c);
    return (c == CHAIN_STATUS) || (c == CHAIN_DATA);
  endfunction

endpackage

// File: rtl/icetap_scan_shreg.sv
// Parallel-load, LSB-first serial-out shift register with indexed bit capture.
// The capture register exists only when ICETAP_SCAN_MASTER_READBACK_EN is defined.
module icetap_scan_shreg #(
  parameter int unsigned W        = 64,
  parameter int unsigned IDX_BITS = 7
) (
  input  logic                scan_clk,
  input  logic                scan_reset,
  input  logic                load,
  input  logic [W-1:0]        load_data,
  input  logic                shift,
  output logic                sout_c,
  input  logic                cap_clr,
  input  logic                cap_en,
  input  logic [IDX_BITS-1:0] cap_idx,
  input  logic                cap_bit,
  output logic [W-1:0]        cap_data
);

  logic [W-1:0] sr_q;
  logic [W-1:0] sr_base;
  logic [W-1:0] sr_d;

  // A load may coincide with the first shift, so the serial bit comes from the load value.
  always_comb begin
    sr_base = load ? load_data : sr_q;
    sout_c  = sr_base[0];
    sr_d    = shift ? (sr_base >> 1) : sr_base;
  end

  always_ff @(posedge scan_clk or posedge scan_reset) begin
    if (scan_reset) sr_q <= '0;
    else            sr_q <= sr_d;
  end

`ifdef ICETAP_SCAN_MASTER_READBACK_EN
  logic [W-1:0] cap_q;

  always_ff @(posedge scan_clk or posedge scan_reset) begin
    if (scan_reset)   cap_q <= '0;
    else if (cap_clr) cap_q <= '0;
    else if (cap_en)  cap_q <= cap_q | (W'(cap_bit) << cap_idx);
  end

  assign cap_data = cap_q;
`else
  logic unused_cap;
  assign unused_cap = ^{cap_clr, cap_en, cap_idx, cap_bit};
  assign cap_data   = '0;
`endif

endmodule

// File: rtl/icetap_scan_master.sv
// Scan master: sequences update/shift cycles on one of five scan chains per request.
// Define ICETAP_SCAN_MASTER_READBACK_EN to capture status/data bits into rsp_rdata.
module icetap_scan_master
  import icetap_scan_pkg::*;
#(
  parameter int unsigned MAX_BITS = 64,
  parameter int unsigned LEN_BITS = $clog2(MAX_BITS + 1)
) (
  input  logic                scan_clk,
  input  logic                scan_reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          req_chain,
  input  logic [LEN_BITS-1:0] req_len,
  input  logic [MAX_BITS-1:0] req_wdata,
  output logic                rsp_valid,
  output logic                rsp_err,
  output logic [MAX_BITS-1:0] rsp_rdata,
  output logic                cmd_shift_ena,
  output logic                cmd_shift_update,
  output logic                cmd_shift_data,
  output logic                status_shift_ena,
  output logic                status_shift_update,
  input  logic                status_shift_data,
  output logic                store_mask_shift_ena,
  output logic                store_mask_shift_data,
  output logic                trigger_mask_shift_ena,
  output logic                trigger_mask_shift_data,
  output logic                data_shift_ena,
  output logic                data_shift_update,
  input  logic                data_shift_data
);

  localparam logic [LEN_BITS-1:0] MAX_LEN = LEN_BITS'(MAX_BITS);

  scan_state_t         state_q, state_d;
  logic [2:0]          chain_q, chain_d;
  logic [LEN_BITS-1:0] len_q, len_d;
  logic [LEN_BITS-1:0] cnt_q, cnt_d;
  logic [LEN_BITS-1:0] len_clamp;
  logic                err_d;
  logic                load;
  logic                shift;
  logic                sout_c;
  logic                cap_en;
  logic                cap_bit;

  assign len_clamp = (req_len > MAX_LEN) ? MAX_LEN : req_len;

  always_ff @(posedge scan_clk or posedge scan_reset) begin
    if (scan_reset) begin
      state_q <= ST_IDLE;
      chain_q <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      chain_q <= chain_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; cnt_q is the index of the bit shifted in the current cycle.
  always_comb begin
    state_d = state_q;
    chain_d = chain_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = rsp_err;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          load    = 1'b1;
          chain_d = req_chain;
          len_d   = len_clamp;
          cnt_d   = '0;
          err_d   = !chain_legal(req_chain);
          if (!chain_legal(req_chain))     state_d = ST_DONE;
          else if (chain_reads(req_chain)) state_d = ST_PRE_UPD;
          else if (len_clamp != '0)        state_d = ST_SHIFT;
          else if (req_chain == CHAIN_CMD) state_d = ST_POST_UPD;
          else                             state_d = ST_DONE;
        end
      end
      ST_PRE_UPD: state_d = (len_q != '0) ? ST_SHIFT : ST_DONE;
      ST_SHIFT: begin
        if ((cnt_q + LEN_BITS'(1)) == len_q)
          state_d = (chain_q == CHAIN_CMD) ? ST_POST_UPD : ST_DONE;
        else
          cnt_d = cnt_q + LEN_BITS'(1);
      end
      ST_POST_UPD: state_d = ST_DONE;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  assign shift   = (state_d == ST_SHIFT);
  assign cap_en  = (state_q == ST_SHIFT) && chain_reads(chain_q);
  assign cap_bit = (chain_q == CHAIN_STATUS) ? status_shift_data : data_shift_data;

  icetap_scan_shreg #(
    .W        (MAX_BITS),
    .IDX_BITS (LEN_BITS)
  ) u_shreg (
    .scan_clk   (scan_clk),
    .scan_reset (scan_reset),
    .load       (load),
    .load_data  (req_wdata),
    .shift      (shift),
    .sout_c     (sout_c),
    .cap_clr    (load),
    .cap_en     (cap_en),
    .cap_idx    (cnt_q),
    .cap_bit    (cap_bit),
    .cap_data   (rsp_rdata)
  );

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge scan_clk or posedge scan_reset) begin
    if (scan_reset) begin
      req_ready               <= 1'b1;
      rsp_valid               <= 1'b0;
      rsp_err                 <= 1'b0;
      cmd_shift_ena           <= 1'b0;
      cmd_shift_update        <= 1'b0;
      cmd_shift_data          <= 1'b0;
      status_shift_ena        <= 1'b0;
      status_shift_update     <= 1'b0;
      store_mask_shift_ena    <= 1'b0;
      store_mask_shift_data   <= 1'b0;
      trigger_mask_shift_ena  <= 1'b0;
      trigger_mask_shift_data <= 1'b0;
      data_shift_ena          <= 1'b0;
      data_shift_update       <= 1'b0;
    end else begin
      req_ready               <= (state_d == ST_IDLE);
      rsp_valid               <= (state_d == ST_DONE);
      rsp_err                 <= err_d;
      cmd_shift_ena           <= shift && (chain_d == CHAIN_CMD);
      cmd_shift_update        <= (state_d == ST_POST_UPD);
      cmd_shift_data          <= shift && (chain_d == CHAIN_CMD) && sout_c;
      status_shift_ena        <= shift && (chain_d == CHAIN_STATUS);
      status_shift_update     <= (state_d == ST_PRE_UPD) && (chain_d == CHAIN_STATUS);
      store_mask_shift_ena    <= shift && (chain_d == CHAIN_STORE_MASK);
      store_mask_shift_data   <= shift && (chain_d == CHAIN_STORE_MASK) && sout_c;
      trigger_mask_shift_ena  <= shift && (chain_d == CHAIN_TRIGGER_MASK);
      trigger_mask_shift_data <= shift && (chain_d == CHAIN_TRIGGER_MASK) && sout_c;
      data_shift_ena          <= shift && (chain_d == CHAIN_DATA);
      data_shift_update       <= (state_d == ST_PRE_UPD) && (chain_d == CHAIN_DATA);
    end
  end

endmodule
